// File: rtl/not_gate_tester_pkg.sv
// Shared types and helpers for the inverter-bank tester.
package tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int unsigned NUM_VECTORS = 4;
  localparam int unsigned MAX_GATES   = 32;

  // Test vector k for a bank of 'width' gates: all-0, all-1, bit i = i[0], and its complement.
  function automatic logic [MAX_GATES-1:0] vec_of(input logic [1:0] idx, input int unsigned width);
    logic [MAX_GATES-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_GATES; i++) begin
      if (i < width) begin
        case (idx)
          2'd0:    v[i] = 1'b0;
          2'd1:    v[i] = 1'b1;
          2'd2:    v[i] = i[0];
          default: v[i] = ~i[0];
        endcase
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/not_gate_tester_if.sv
// Drive/response bus between the tester and the inverter bank.
interface not_gate_tester_if #(
  parameter int unsigned NUM_GATES = 6
);
  logic [NUM_GATES-1:0] dut_a;
  logic [NUM_GATES-1:0] dut_z;

  modport master (output dut_a, input dut_z);
  modport slave  (input dut_a, output dut_z);
endinterface

// File: rtl/not_gate_tester_bit_synchronizer.sv
// Multi-stage flop synchronizer for signals asynchronous to clk.
module bit_synchronizer #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  // Shift the input through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < STAGES; s++) chain[s] <= '0;
    end else begin
      chain[0] <= d;
      for (int unsigned s = 1; s < STAGES; s++) chain[s] <= chain[s-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/not_gate_tester.sv
// Applies four fixed vectors to an inverter bank and reports per-gate failures.
module not_gate_tester
  import tester_pkg::*;
#(
  parameter int unsigned NUM_GATES     = 6,
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  not_gate_tester_if.master    gates,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_GATES-1:0] fail_mask
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

  state_t               state;
  logic [1:0]           vec_idx;
  logic [CNT_W-1:0]     settle_cnt;
  logic [NUM_GATES-1:0] dut_a;
  logic [NUM_GATES-1:0] z_sync;
  logic [NUM_GATES-1:0] mismatch_c;
  logic [NUM_GATES-1:0] first_vec_c;
  logic [NUM_GATES-1:0] next_vec_c;

  assign gates.dut_a = dut_a;

  // Bring the asynchronous inverter outputs into the clk domain.
  bit_synchronizer #(
    .WIDTH  (NUM_GATES),
    .STAGES (SYNC_STAGES)
  ) u_z_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gates.dut_z),
    .q     (z_sync)
  );

  // Per-gate mismatch against the expected inverted drive, plus vector lookups.
  always_comb begin
    mismatch_c  = z_sync ^ ~dut_a;
    first_vec_c = NUM_GATES'(vec_of(2'd0, NUM_GATES));
    next_vec_c  = NUM_GATES'(vec_of(vec_idx + 2'd1, NUM_GATES));
  end

  // Sequencer: drive vector, let it settle through the synchronizer, sample, repeat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      vec_idx    <= '0;
      settle_cnt <= '0;
      dut_a      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_mask  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_DRIVE;
            dut_a     <= first_vec_c;
            vec_idx   <= '0;
            fail_mask <= '0;
            pass      <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_DRIVE: begin
          settle_cnt <= '0;
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            state <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end
        ST_SAMPLE: begin
          fail_mask <= fail_mask | mismatch_c;
          if (vec_idx != 2'(NUM_VECTORS - 1)) begin
            vec_idx <= vec_idx + 2'd1;
            dut_a   <= next_vec_c;
            state   <= ST_DRIVE;
          end else begin
            pass  <= ((fail_mask | mismatch_c) == '0);
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          dut_a <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_not_gate_tester.sv
// Bench for not_gate_tester: faulty inverter-bank model, table cases, corner sequences, random faults.
module tb_not_gate_tester;

  localparam int unsigned G = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         busy;
  logic         done;
  logic         pass;
  logic [G-1:0] fail_mask;

  // Fault injection controls for the inverter-bank model.
  logic [G-1:0] s0;
  logic [G-1:0] s1;
  logic [G-1:0] bufm;
  logic [G-1:0] glitch;
  logic         bridge;
  logic [G-1:0] zm;

  int checks   = 0;
  int failures = 0;

  not_gate_tester_if #(.NUM_GATES(G)) gif ();

  // Zero-delay inverter bank with optional buffer gates, 0/1 bridge, stuck-at and glitch faults.
  always_comb begin
    zm = (~gif.dut_a & ~bufm) | (gif.dut_a & bufm);
    if (bridge) zm[1] = zm[0];
    zm = (zm & ~s0) | s1;
    zm = zm ^ glitch;
  end

  assign gif.dut_z = zm;

  not_gate_tester #(
    .NUM_GATES     (G),
    .SETTLE_CYCLES (3),
    .SYNC_STAGES   (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .gates     (gif),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_mask (fail_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [G-1:0] s0;
    logic [G-1:0] s1;
    logic [G-1:0] bufm;
    logic         bridge;
    logic [G-1:0] exp_mask;
    int           mode;
  } case_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Vector k from its definition: all-0, all-1, odd bits set, even bits set.
  function automatic logic [G-1:0] ref_vec(input int k);
    logic [G-1:0] v;
    for (int i = 0; i < G; i++) begin
      case (k)
        0:       v[i] = 1'b0;
        1:       v[i] = 1'b1;
        2:       v[i] = (i % 2) == 1;
        default: v[i] = (i % 2) == 0;
      endcase
    end
    return v;
  endfunction

  // Expected fail mask: evaluate each faulty gate on each vector and flag any Z != ~A.
  function automatic logic [G-1:0] ref_mask(input logic [G-1:0] s0_i, input logic [G-1:0] s1_i,
                                            input logic [G-1:0] buf_i, input logic br);
    logic [G-1:0] m;
    logic [G-1:0] a;
    m = '0;
    for (int k = 0; k < 4; k++) begin
      a = ref_vec(k);
      for (int i = 0; i < G; i++) begin
        int src;
        bit o;
        src = (br && i == 1) ? 0 : i;
        o = buf_i[src] ? a[src] : !a[src];
        if (s0_i[i]) o = 1'b0;
        if (s1_i[i]) o = 1'b1;
        if (o == a[i]) m[i] = 1'b1;
      end
    end
    return m;
  endfunction

  // One full run from IDLE. mode 1: start pulses while busy; mode 2: glitch on z[3] in DRIVE of V1.
  task automatic run(input string tag, input logic [G-1:0] exp_mask, input int mode);
    int   done_cnt;
    int   done_at;
    logic exp_pass;
    exp_pass = (exp_mask == '0);
    done_cnt = 0;
    done_at  = -1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k <= 22; k++) begin
      if (k > 0) step();
      if ((k % 5) == 0 && k < 20) check({tag, " dut_a"}, 32'(gif.dut_a), 32'(ref_vec(k / 5)));
      if (k == 0) begin
        check({tag, " busy_start"}, 32'(busy), 32'd1);
        check({tag, " pass_clr"}, 32'(pass), 32'd0);
        check({tag, " mask_clr"}, 32'(fail_mask), 32'd0);
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k == 20) begin
        check({tag, " pass"}, 32'(pass), 32'(exp_pass));
        check({tag, " fail_mask"}, 32'(fail_mask), 32'(exp_mask));
        check({tag, " busy_done"}, 32'(busy), 32'd1);
      end
      if (k == 21) begin
        check({tag, " busy_idle"}, 32'(busy), 32'd0);
        check({tag, " dut_a_idle"}, 32'(gif.dut_a), 32'd0);
      end
      if (mode == 1) begin
        if (k == 7)  start = 1'b1;
        if (k == 8)  start = 1'b0;
        if (k == 20) start = 1'b1;
        if (k == 21) start = 1'b0;
      end
      if (mode == 2) begin
        if (k == 5) glitch = G'(6'b001000);
        if (k == 6) glitch = '0;
      end
    end
    check({tag, " done_count"}, 32'(done_cnt), 32'd1);
    check({tag, " done_cycle"}, 32'(done_at), 32'd20);
    check({tag, " pass_held"}, 32'(pass), 32'(exp_pass));
    check({tag, " mask_held"}, 32'(fail_mask), 32'(exp_mask));
    check({tag, " busy_held"}, 32'(busy), 32'd0);
  endtask

  case_t tbl [6];

  initial begin
    logic [G-1:0] exp_r;

    tbl[0] = '{"ideal",     '0,              '0, '0,              1'b0, '0,              0};
    tbl[1] = '{"sa0_g2",    G'(6'b000100),   '0, '0,              1'b0, G'(6'b000100),   0};
    tbl[2] = '{"buf_g5",    '0,              '0, G'(6'b100000),   1'b0, G'(6'b100000),   0};
    tbl[3] = '{"bridge01",  '0,              '0, '0,              1'b1, G'(6'b000010),   0};
    tbl[4] = '{"busy_start",'0,              '0, '0,              1'b0, '0,              1};
    tbl[5] = '{"glitch",    '0,              '0, '0,              1'b0, '0,              2};

    s0 = '0; s1 = '0; bufm = '0; glitch = '0; bridge = 1'b0;
    start = 1'b0;
    rst_n = 1'b0;
    repeat (2) step();
    check("rst dut_a", 32'(gif.dut_a), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst pass", 32'(pass), 32'd0);
    check("rst mask", 32'(fail_mask), 32'd0);
    rst_n = 1'b1;
    repeat (2) step();

    for (int t = 0; t < 6; t++) begin
      s0 = tbl[t].s0; s1 = tbl[t].s1; bufm = tbl[t].bufm; bridge = tbl[t].bridge;
      run(tbl[t].name, tbl[t].exp_mask, tbl[t].mode);
      step();
    end

    // Reset during SETTLE of V2 after a failure has been recorded.
    s0 = G'(6'b000100); s1 = '0; bufm = '0; bridge = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (12) step();
    check("mid mask_pre", 32'(fail_mask), 32'(6'b000100));
    rst_n = 1'b0;
    #1;
    check("mid dut_a", 32'(gif.dut_a), 32'd0);
    check("mid busy", 32'(busy), 32'd0);
    check("mid pass", 32'(pass), 32'd0);
    check("mid mask", 32'(fail_mask), 32'd0);
    step();
    rst_n = 1'b1;
    s0 = '0;
    step();
    run("post_reset", '0, 0);
    step();

    // Random fault combinations against the reference model.
    for (int r = 0; r < 20; r++) begin
      s0     = G'($urandom) & G'($urandom) & G'($urandom);
      s1     = G'($urandom) & G'($urandom) & G'($urandom);
      bufm   = G'($urandom) & G'($urandom);
      bridge = 1'($urandom_range(0, 1));
      exp_r  = ref_mask(s0, s1, bufm, bridge);
      run($sformatf("rand%0d", r), exp_r, 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
